bee_game_ctrl: RTL and testbench

- Game-flow controller downstream of the collision detector: consumes its lose flag L once per frame.
- Sequences title → play → dying → game-over, with restart.
- Keeps a 4-digit BCD score and high score for the HUD.
- Drives the enables that freeze or release the bee and obstacle motion blocks.

---
 rtl/bee_pkg.sv | 6 +
 rtl/bcd_counter4.sv | 29 ++
 rtl/bee_game_ctrl.sv | 89 ++++++++
 tb/tb_bee_game_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bee_pkg.sv
// bee_pkg: shared types and constants for the bee game controller
package bee_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DYING = 2'b10, OVER = 2'b11} game_state_t;
  typedef logic [15:0] bcd4_t;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: saturating 4-digit BCD counter with synchronous clear
module bcd_counter4
  import bee_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  inc,
  output bcd4_t q
);
  bcd4_t nxt;
  logic  c;
  // ripple a +1 through the digits, wrapping each 9 to 0 and carrying on
  always_comb begin
    nxt = q;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        nxt[4*i +: 4] = q[4*i +: 4] == 4'd9 ? 4'd0 : q[4*i +: 4] + 4'd1;
        c = q[4*i +: 4] == 4'd9;
      end
    end
  end
  // clear wins over increment; 9999 holds instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (inc && q != 16'h9999) q <= nxt;
  end
endmodule

// File: rtl/bee_game_ctrl.sv
// bee_game_ctrl: title/play/dying/over flow, BCD score and high score
module bee_game_ctrl
  import bee_pkg::*;
#(
  parameter logic [7:0] START_KEY    = KEY_SPACE,
  parameter int         HIT_FRAMES   = 2,
  parameter int         DEATH_FRAMES = 60,
  parameter int         RESTART_LOCK = 30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        L,
  input  logic        obs_passed,
  output logic [1:0]  game_state,
  output logic        play_en,
  output logic        dying,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        new_record
);
  game_state_t state;
  logic        key_prev;
  logic [3:0]  hit_cnt;
  logic [7:0]  die_cnt;
  logic [7:0]  lock_cnt;
  logic        key_now, start, hit_q, die_done;
  assign key_now    = keycode == START_KEY;
  assign start      = key_now && !key_prev && (state == IDLE || (state == OVER && lock_cnt == 8'(RESTART_LOCK)));
  assign hit_q      = state == PLAY && L && hit_cnt == 4'(HIT_FRAMES - 1);
  assign die_done   = state == DYING && die_cnt == 8'(DEATH_FRAMES - 1);
  assign game_state = state;
  bcd_counter4 u_score (
    .clk(frame_clk),
    .rst(Reset),
    .clr(start),
    .inc(state == PLAY && obs_passed && !hit_q),
    .q  (score)
  );
  // game flow FSM; play_en/dying are set alongside each state change
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      play_en    <= 1'b0;
      dying      <= 1'b0;
      high_score <= '0;
      new_record <= 1'b0;
      hit_cnt    <= '0;
      die_cnt    <= '0;
      lock_cnt   <= '0;
      key_prev   <= 1'b0;
    end else begin
      key_prev <= key_now;
      if (start) begin
        state      <= PLAY;
        play_en    <= 1'b1;
        dying      <= 1'b0;
        new_record <= 1'b0;
        hit_cnt    <= '0;
      end else begin
        case (state)
          PLAY: begin
            hit_cnt <= L ? hit_cnt + 4'd1 : 4'd0;
            if (hit_q) begin
              state   <= DYING;
              play_en <= 1'b0;
              dying   <= 1'b1;
              die_cnt <= '0;
            end
          end
          DYING: begin
            die_cnt <= die_cnt + 8'd1;
            if (die_done) begin
              state    <= OVER;
              dying    <= 1'b0;
              lock_cnt <= '0;
              if (score > high_score) begin
                high_score <= score;
                new_record <= 1'b1;
              end
            end
          end
          OVER: lock_cnt <= lock_cnt == 8'(RESTART_LOCK) ? lock_cnt : lock_cnt + 8'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bee_game_ctrl.sv
// tb_bee_game_ctrl: directed plus random checks against a frame-level game model
module tb_bee_game_ctrl;
  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic        L = 1'b0;
  logic        obs_passed = 1'b0;
  logic [1:0]  game_state;
  logic        play_en, dying, new_record;
  logic [15:0] score, high_score;
  int tests = 0;
  int fails = 0;
  int m_state, m_score, m_high, m_hit, m_die, m_lock;
  bit m_new, m_kprev;
  bee_game_ctrl dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .L(L),
    .obs_passed(obs_passed),
    .game_state(game_state),
    .play_en(play_en),
    .dying(dying),
    .score(score),
    .high_score(high_score),
    .new_record(new_record)
  );
  always #5 frame_clk = ~frame_clk;
  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("game_state", 16'(game_state), 16'(m_state));
    chk("play_en", 16'(play_en), 16'(m_state == 1));
    chk("dying", 16'(dying), 16'(m_state == 2));
    chk("score", score, to_bcd(m_score));
    chk("high_score", high_score, to_bcd(m_high));
    chk("new_record", 16'(new_record), 16'(m_new));
  endtask
  task automatic model(input bit rst, input logic [7:0] k, input bit l, input bit o);
    bit edge_k;
    edge_k = (k == 8'h2C) && !m_kprev;
    if (rst) begin
      m_state = 0; m_score = 0; m_high = 0; m_hit = 0; m_die = 0; m_lock = 0; m_new = 0; m_kprev = 0;
      return;
    end
    if (edge_k && (m_state == 0 || (m_state == 3 && m_lock == 30))) begin
      m_state = 1; m_score = 0; m_new = 0; m_hit = 0;
    end else if (m_state == 1) begin
      if (l && m_hit == 1) begin
        m_state = 2; m_die = 0;
      end else begin
        m_hit = l ? m_hit + 1 : 0;
        if (o && m_score < 9999) m_score++;
      end
    end else if (m_state == 2) begin
      if (m_die == 59) begin
        m_state = 3; m_lock = 0;
        if (m_score > m_high) begin m_high = m_score; m_new = 1; end
      end else m_die++;
    end else if (m_state == 3) begin
      if (m_lock < 30) m_lock++;
    end
    m_kprev = (k == 8'h2C);
  endtask
  task automatic step(input bit rst, input logic [7:0] k, input bit l, input bit o);
    Reset = rst; keycode = k; L = l; obs_passed = o;
    model(rst, k, l, o);
    @(posedge frame_clk);
    #1;
    check_all();
  endtask
  initial begin
    #1;
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    chk("reset_state", 16'(game_state), 16'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h2C, 0, 0);
      if (i == 0) chk("first_key_play_en", 16'(play_en), 16'd1);
    end
    chk("held_key_score", score, 16'h0000);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
    end
    chk("score_12", score, 16'h0012);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("isolated_L_stays_play", 16'(game_state), 16'd1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 1);
    chk("hit_to_dying", 16'(game_state), 16'd2);
    chk("hit_wins_over_obs", score, 16'h0012);
    for (int i = 0; i < 60; i++) step(0, 8'h00, i[0], i[1]);
    chk("over_state", 16'(game_state), 16'd3);
    chk("over_high", high_score, 16'h0012);
    chk("over_new_record", 16'(new_record), 16'd1);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 0);
    step(0, 8'h2C, 0, 0);
    chk("locked_start_ignored", 16'(game_state), 16'd3);
    for (int i = 0; i < 25; i++) step(0, 8'h00, 0, 0);
    step(0, 8'h2C, 0, 0);
    chk("restart_play", 16'(game_state), 16'd1);
    chk("restart_score", score, 16'h0000);
    chk("restart_new_record", 16'(new_record), 16'd0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 10001; i++) step(0, 8'h00, 0, 1);
    chk("score_saturates", score, 16'h9999);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);
    chk("pre_reset_dying", 16'(game_state), 16'd2);
    step(1, 8'h00, 0, 0);
    chk("reset_in_dying_high", high_score, 16'h0000);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 599) == 0, ($urandom_range(0, 3) == 0) ? 8'h2C : 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : 0),
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
